// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared opcodes, FSM states and command-entry layout for the
//               ALU command sequencer. ALU_SEQ_ACC_EN adds the use_acc field.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_GT  = 4'b1000;
    localparam logic [3:0] OP_EQ  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Tag is appended by the top because its width is a top-level parameter
    typedef struct packed {
`ifdef ALU_SEQ_ACC_EN
        logic       use_acc;
`endif
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } cmd_fields_t;

    localparam int CMD_FIELDS_W = $bits(cmd_fields_t);

endpackage

`default_nettype wire

// File: rtl/alu_seq_fifo.sv
// ============================================================================
// Module      : alu_seq_fifo
// Description : Synchronous FIFO with wrap-bit pointers and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_push;
    logic             w_pop;

    // Push is gated on full alone, so a pop in the same cycle never frees a slot early
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Buffers tagged ALU commands, drives the ALU and returns
//               in-order tagged responses. ALU_SEQ_ACC_EN adds accumulator
//               chaining through cmd_use_acc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [3:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
`ifdef ALU_SEQ_ACC_EN
    input  logic             cmd_use_acc,
`endif
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [7:0]       alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int ENTRY_W = CMD_FIELDS_W + TAG_W;

    typedef struct packed {
        cmd_fields_t      f;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           w_push_entry;
    entry_t           w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;

    state_e           state_q, state_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
`ifdef ALU_SEQ_ACC_EN
    logic [7:0]       acc_q, acc_d;
`endif

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.f.a   = cmd_a;
        w_push_entry.f.b   = cmd_b;
        w_push_entry.f.op  = cmd_op;
        w_push_entry.tag   = cmd_tag;
`ifdef ALU_SEQ_ACC_EN
        w_push_entry.f.use_acc = cmd_use_acc;
`endif
    end

    alu_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid),
        .wdata_i (w_push_entry),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_comb begin
        state_d      = state_q;
        w_pop        = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        tag_d        = tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_tag_d    = rsp_tag_q;
        op_count_d   = op_count_q;
`ifdef ALU_SEQ_ACC_EN
        acc_d        = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
`ifdef ALU_SEQ_ACC_EN
                    alu_a_d  = w_head.f.use_acc ? acc_q : w_head.f.a;
`else
                    alu_a_d  = w_head.f.a;
`endif
                    alu_b_d  = w_head.f.b;
                    alu_op_d = w_head.f.op;
                    tag_d    = w_head.tag;
                    state_d  = ST_EXEC;
                end
            end
            // ALU inputs have been stable for a full cycle by this edge
            ST_EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_carry_d  = alu_carry;
                rsp_tag_d    = tag_q;
                rsp_valid_d  = 1'b1;
`ifdef ALU_SEQ_ACC_EN
                acc_d        = alu_result;
`endif
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_tag_q    <= '0;
            op_count_q   <= '0;
`ifdef ALU_SEQ_ACC_EN
            acc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_tag_q    <= rsp_tag_d;
            op_count_q   <= op_count_d;
`ifdef ALU_SEQ_ACC_EN
            acc_q        <= acc_d;
`endif
        end
    end

    assign cmd_ready  = !w_full;
    assign busy       = (state_q != ST_IDLE) || !w_empty;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_tag    = rsp_tag_q;
    assign op_count   = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer with an ALU model,
//               a cycle-level reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH = 4;
`ifdef ALU_SEQ_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_a = '0, cmd_b = '0;
    logic [3:0]  cmd_op = '0, cmd_tag = '0;
    logic        cmd_use_acc = 1'b0;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_zero, alu_carry;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_result;
    logic        rsp_zero, rsp_carry;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic [15:0] op_count;

    logic rdy_lvl = 1'b1, tog_en = 1'b0, tog_q = 1'b0, rnd_en = 1'b0, rnd_q = 1'b0;
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tog_q <= ~tog_q;
        rnd_q <= 1'($urandom);
    end
    assign rsp_ready = rnd_en ? rnd_q : (tog_en ? tog_q : rdy_lvl);

    alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
`ifdef ALU_SEQ_ACC_EN
        .cmd_use_acc(cmd_use_acc),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_tag(rsp_tag), .busy(busy), .op_count(op_count)
    );

    // Returns {carry, zero, result}
    function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
        logic [8:0] s;
        case (op)
            OP_ADD:  s = {1'b0, a} + {1'b0, b};
            OP_SUB:  s = {1'b0, a} - {1'b0, b};
            OP_AND:  s = {1'b0, a & b};
            OP_OR:   s = {1'b0, a | b};
            OP_XOR:  s = {1'b0, a ^ b};
            OP_SHL:  s = {a, 1'b0};
            OP_GT:   s = {8'd0, a > b};
            OP_EQ:   s = {8'd0, a == b};
            default: s = {1'b0, ~(a ^ b)};
        endcase
        return {s[8], s[7:0] == 8'd0, s[7:0]};
    endfunction

    always_comb {alu_carry, alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_opcode);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting commands plus a three-phase engine
    typedef struct {
        logic [7:0] a, b;
        logic [3:0] op, tag;
        logic       ua;
    } mcmd_t;

    mcmd_t       mq[$];
    mcmd_t       mc, nc;
    int          ph = 0;
    logic        ev = 1'b0, ez = 1'b0, ecy = 1'b0, take;
    logic [7:0]  ea = '0, eb = '0, er = '0, acc_m = '0;
    logic [3:0]  eo = '0, et = '0;
    logic [15:0] ecnt = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            ph = 0; ev = 0; ez = 0; ecy = 0; ea = 0; eb = 0; er = 0;
            eo = 0; et = 0; ecnt = 0; acc_m = 0;
        end else begin
            take = cmd_valid && (mq.size() < DEPTH);
            if (ph == 2) begin
                if (rsp_ready) begin ev = 0; ecnt++; ph = 0; end
            end else if (ph == 1) begin
                {ecy, ez, er} = alu_f(ea, eb, eo);
                et = mc.tag; ev = 1; acc_m = er; ph = 2;
            end else if (mq.size() > 0) begin
                mc = mq.pop_front();
                ea = mc.ua ? acc_m : mc.a;
                eb = mc.b; eo = mc.op; ph = 1;
            end
            if (take) begin
                nc.a = cmd_a; nc.b = cmd_b; nc.op = cmd_op; nc.tag = cmd_tag;
                nc.ua = ACC ? cmd_use_acc : 1'b0;
                mq.push_back(nc);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
            chk("rsp_valid", rsp_valid, ev);
            chk("busy", busy, (ph != 0) || (mq.size() > 0));
            chk("op_count", op_count, ecnt);
            chk("alu_inputs", {alu_a, alu_b, alu_opcode}, {ea, eb, eo});
            if (ev) chk("rsp_fields", {rsp_result, rsp_zero, rsp_carry, rsp_tag},
                        {er, ez, ecy, et});
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic [3:0] tag, input logic ua);
        logic ok = 1'b0;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_use_acc = ua;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); ok = cmd_ready;
            @(posedge clk); #2;
        end
        cmd_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_rsp();
        logic seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk); seen = rsp_valid;
        end
        if (!seen) chk("rsp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        logic idle = 1'b0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk); idle = !busy;
        end
        if (!idle) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int seen;
        #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_op_count", op_count, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        // Latency and basic ADD
        send(8'd10, 8'd5, OP_ADD, 4'd1, 1'b0);
        @(posedge clk); #1;
        chk("lat_k1_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("lat_k2_valid", rsp_valid, 1);
        chk("add_result", {rsp_result, rsp_zero, rsp_carry, rsp_tag}, {8'd15, 1'b0, 1'b0, 4'd1});
        @(posedge clk); #1;
        chk("add_op_count", op_count, 1);
        #1;

        send(8'd5, 8'd5, OP_SUB, 4'd2, 1'b0);
        wait_rsp();
        chk("sub_result", {rsp_result, rsp_zero, rsp_tag}, {8'd0, 1'b1, 4'd2});
        @(posedge clk); #2;
        send(8'd200, 8'd100, OP_ADD, 4'd3, 1'b0);
        wait_rsp();
        chk("add_carry", {rsp_result, rsp_carry}, {8'd44, 1'b1});
        wait_idle();
        @(posedge clk); #2;

        // Stall: four buffered plus one in flight fills the block
        rdy_lvl = 1'b0;
        send(8'b1100, 8'b1010, OP_AND, 4'd3, 1'b0);
        send(8'b1100, 8'b1010, OP_OR,  4'd4, 1'b0);
        send(8'b1100, 8'b1010, OP_XOR, 4'd5, 1'b0);
        send(8'b1100, 8'b1010, OP_SHL, 4'd6, 1'b0);
        send(8'd30,   8'd10,   OP_GT,  4'd7, 1'b0);
        repeat (3) @(negedge clk);
        chk("stall_cmd_ready", cmd_ready, 0);
        chk("stall_first", {rsp_valid, rsp_result, rsp_tag}, {1'b1, 8'd8, 4'd3});
        @(negedge clk);
        chk("stall_stable", {rsp_valid, rsp_result, rsp_tag}, {1'b1, 8'd8, 4'd3});
        @(posedge clk); #2;
        rdy_lvl = 1'b1;
        send(8'd9, 8'd9, OP_EQ, 4'd8, 1'b0);
        wait_idle();
        @(posedge clk); #2;

        // Reset while executing with three entries waiting
        for (int i = 0; i < 5; i++) send(8'(i * 3), 8'(i), OP_ADD, 4'(i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_ready", cmd_ready, 1);
        chk("mid_reset_outs", {rsp_valid, busy, alu_a, alu_opcode, rsp_result},
            {1'b0, 1'b0, 8'd0, 4'd0, 8'd0});
        chk("mid_reset_count", op_count, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (15) begin @(negedge clk); if (rsp_valid) seen++; end
        chk("no_rsp_after_reset", seen, 0);
        @(posedge clk); #2;

        // Back-to-back with toggling ready
        tog_en = 1'b1;
        send(8'd7, 8'd7, OP_EQ, 4'd9, 1'b0);
        send(8'd20, 8'd10, OP_GT, 4'd10, 1'b0);
        wait_idle();
        @(negedge clk);
        chk("toggle_op_count", op_count, 2);
        tog_en = 1'b0;
        @(posedge clk); #2;

`ifdef ALU_SEQ_ACC_EN
        send(8'd10, 8'd5, OP_ADD, 4'd1, 1'b0);
        wait_rsp();
        chk("acc_first", rsp_result, 8'd15);
        @(posedge clk); #2;
        send(8'd99, 8'd3, OP_ADD, 4'd2, 1'b1);
        wait_rsp();
        chk("acc_chain", rsp_result, 8'd18);
        wait_idle();
        @(posedge clk); #2;
`endif

        // Randomized traffic with random backpressure
        rnd_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
            send(8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 1)));
        end
        rnd_en = 1'b0;
        rdy_lvl = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
